// File: rtl/if_id_stage.sv
// IF/ID pipeline register with flush, hold, sticky halt and optional load-use stall.
// Load-use hazard detection is compiled in only when IF_ID_HAZARD_EN is defined.
module if_id_stage #(
  parameter logic [15:0] BUBBLE_INSTR = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] if_instruction,
  input  logic [15:0] if_PC,
  input  logic [15:0] if_PC_plus_two,
  input  logic        flush,
  input  logic        ext_stall,
  input  logic        idex_mem_read,
  input  logic [3:0]  idex_rd,
  output logic [15:0] id_instruction,
  output logic [15:0] id_PC,
  output logic [15:0] id_PC_plus_two,
  output logic        id_valid,
  output logic [3:0]  id_opcode,
  output logic [3:0]  id_rd,
  output logic [3:0]  id_rs,
  output logic [3:0]  id_rt,
  output logic        id_halt,
  output logic        stall
);

  logic hazard;
  logic halt_now;
  logic hold;

  assign id_opcode = id_instruction[15:12];
  assign id_rd     = id_instruction[11:8];
  assign id_rs     = id_instruction[7:4];
  assign id_rt     = id_instruction[3:0];

`ifdef IF_ID_HAZARD_EN
  assign hazard = id_valid & idex_mem_read & (idex_rd != 4'h0) &
                  ((idex_rd == id_rs) | (idex_rd == id_rt));
`else
  logic unused_hazard_inputs;
  assign unused_hazard_inputs = ^{idex_mem_read, idex_rd};
  assign hazard = 1'b0;
`endif

  assign halt_now = id_valid & (id_opcode == 4'hF);
  assign hold     = ext_stall | hazard | id_halt;
  assign stall    = hold | halt_now;

  // Once halted the whole slot is frozen, so the halted check sits above flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_instruction <= BUBBLE_INSTR;
      id_PC          <= '0;
      id_PC_plus_two <= '0;
      id_valid       <= 1'b0;
      id_halt        <= 1'b0;
    end else if (!id_halt) begin
      if (halt_now && !flush) begin
        id_halt <= 1'b1;
      end
      if (flush) begin
        id_instruction <= BUBBLE_INSTR;
        id_PC          <= '0;
        id_PC_plus_two <= '0;
        id_valid       <= 1'b0;
      end else if (!hold) begin
        id_instruction <= if_instruction;
        id_PC          <= if_PC;
        id_PC_plus_two <= if_PC_plus_two;
        id_valid       <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_if_id_stage.sv
// Self-checking bench for if_id_stage: directed scenarios plus randomized traffic
// checked against a rule-level model of the ID slot.
module tb_if_id_stage;

  localparam logic [15:0] BUBBLE = 16'h0000;
`ifdef IF_ID_HAZARD_EN
  localparam bit HZ_EN = 1'b1;
`else
  localparam bit HZ_EN = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic [15:0] if_instruction, if_PC, if_PC_plus_two;
  logic        flush, ext_stall, idex_mem_read;
  logic [3:0]  idex_rd;
  logic [15:0] id_instruction, id_PC, id_PC_plus_two;
  logic        id_valid, id_halt, stall;
  logic [3:0]  id_opcode, id_rd, id_rs, id_rt;

  int errors = 0;
  int checks = 0;

  // Model of the ID slot
  logic [15:0] m_instr, m_pc, m_pc2;
  logic        m_valid, m_halt;

  if_id_stage #(.BUBBLE_INSTR(BUBBLE)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_instruction(if_instruction), .if_PC(if_PC), .if_PC_plus_two(if_PC_plus_two),
    .flush(flush), .ext_stall(ext_stall), .idex_mem_read(idex_mem_read), .idex_rd(idex_rd),
    .id_instruction(id_instruction), .id_PC(id_PC), .id_PC_plus_two(id_PC_plus_two),
    .id_valid(id_valid), .id_opcode(id_opcode), .id_rd(id_rd), .id_rs(id_rs), .id_rt(id_rt),
    .id_halt(id_halt), .stall(stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic m_hazard();
    if (!HZ_EN) return 1'b0;
    return m_valid && idex_mem_read && (idex_rd != 4'h0) &&
           (idex_rd == m_instr[7:4] || idex_rd == m_instr[3:0]);
  endfunction

  function automatic logic m_stall();
    return ext_stall || m_hazard() || m_halt || (m_valid && m_instr[15:12] == 4'hF);
  endfunction

  function automatic logic [66:0] exp_vec();
    return {m_instr, m_pc, m_pc2, m_valid, m_halt,
            m_instr[15:12], m_instr[11:8], m_instr[7:4], m_instr[3:0], m_stall()};
  endfunction

  function automatic logic [66:0] dut_vec();
    return {id_instruction, id_PC, id_PC_plus_two, id_valid, id_halt,
            id_opcode, id_rd, id_rs, id_rt, stall};
  endfunction

  task automatic model_reset();
    m_instr = BUBBLE; m_pc = '0; m_pc2 = '0; m_valid = 1'b0; m_halt = 1'b0;
  endtask

  task automatic drive(input logic [15:0] ins, input logic [15:0] pc,
                       input logic fl, input logic es);
    if_instruction = ins; if_PC = pc; if_PC_plus_two = pc + 16'd2;
    flush = fl; ext_stall = es;
  endtask

  // One rising edge; the model applies flush > hold > load using the inputs seen at the edge.
  task automatic tick();
    logic hz, hn;
    @(posedge clk);
    hz = m_hazard();
    hn = m_valid && (m_instr[15:12] == 4'hF);
    if (!m_halt) begin
      if (flush) begin
        m_instr = BUBBLE; m_pc = '0; m_pc2 = '0; m_valid = 1'b0;
      end else if (!(ext_stall || hz)) begin
        m_instr = if_instruction; m_pc = if_PC; m_pc2 = if_PC_plus_two; m_valid = 1'b1;
      end
      if (hn && !flush) m_halt = 1'b1;
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(16'h0000, 16'h0000, 1'b0, 1'b0);
    idex_mem_read = 1'b0; idex_rd = 4'h0;
    model_reset();
    #1;
    checks++;
    if (dut_vec() !== {BUBBLE, 16'h0000, 16'h0000, 1'b0, 1'b0, BUBBLE, 1'b0}) begin
      errors++;
      $display("FAIL reset_state got=%h required=%h", dut_vec(),
               {BUBBLE, 16'h0000, 16'h0000, 1'b0, 1'b0, BUBBLE, 1'b0});
    end
    #6 rst_n = 1'b1;
  endtask

  task automatic test_load();
    drive(16'h1234, 16'h0010, 1'b0, 1'b0);
    tick();
    checks++;
    if ({id_instruction, id_PC, id_PC_plus_two, id_valid} !== {16'h1234, 16'h0010, 16'h0012, 1'b1}) begin
      errors++;
      $display("FAIL load_slot got=%h/%h/%h/%b required=1234/0010/0012/1",
               id_instruction, id_PC, id_PC_plus_two, id_valid);
    end
    checks++;
    if ({id_opcode, id_rd, id_rs, id_rt} !== 16'h1234) begin
      errors++;
      $display("FAIL load_fields got=%h %h %h %h required=1 2 3 4", id_opcode, id_rd, id_rs, id_rt);
    end
  endtask

  task automatic test_hazard();
    drive(16'h1050, 16'h0020, 1'b0, 1'b0);
    tick();
    drive(16'h2222, 16'h0030, 1'b0, 1'b0);
    idex_mem_read = 1'b1; idex_rd = 4'h5;
    #1;
    checks++;
    if (stall !== HZ_EN) begin
      errors++;
      $display("FAIL hazard_stall got=%b required=%b", stall, HZ_EN);
    end
    tick();
    checks++;
    if (id_instruction !== (HZ_EN ? 16'h1050 : 16'h2222)) begin
      errors++;
      $display("FAIL hazard_hold got=%h required=%h", id_instruction, HZ_EN ? 16'h1050 : 16'h2222);
    end
    idex_rd = 4'h0;
    #1;
    checks++;
    if (stall !== 1'b0) begin
      errors++;
      $display("FAIL hazard_rd0 got=%b required=0", stall);
    end
    tick();
    checks++;
    if (id_instruction !== 16'h2222 || id_PC !== 16'h0030) begin
      errors++;
      $display("FAIL hazard_release got=%h/%h required=2222/0030", id_instruction, id_PC);
    end
    idex_mem_read = 1'b0;
  endtask

  task automatic test_flush_priority();
    drive(16'h3456, 16'h0040, 1'b1, 1'b1);
    tick();
    checks++;
    if ({id_valid, id_instruction, id_PC, id_PC_plus_two} !== {1'b0, BUBBLE, 16'h0000, 16'h0000}) begin
      errors++;
      $display("FAIL flush_over_hold got=%b/%h/%h/%h required=0/%h/0000/0000",
               id_valid, id_instruction, id_PC, id_PC_plus_two, BUBBLE);
    end
    drive(16'h4567, 16'h0044, 1'b0, 1'b1);
    tick();
    checks++;
    if (id_valid !== 1'b0 || id_instruction !== BUBBLE) begin
      errors++;
      $display("FAIL ext_hold got=%b/%h required=0/%h", id_valid, id_instruction, BUBBLE);
    end
    ext_stall = 1'b0;
    tick();
    checks++;
    if (id_valid !== 1'b1 || id_instruction !== 16'h4567 || id_PC_plus_two !== 16'h0046) begin
      errors++;
      $display("FAIL load_after_hold got=%b/%h/%h required=1/4567/0046",
               id_valid, id_instruction, id_PC_plus_two);
    end
  endtask

  task automatic test_halt_flush();
    drive(16'hF000, 16'h0050, 1'b0, 1'b0);
    tick();
    drive(16'h1111, 16'h0054, 1'b1, 1'b0);
    tick();
    checks++;
    if (id_halt !== 1'b0 || id_valid !== 1'b0) begin
      errors++;
      $display("FAIL halt_squashed got=halt%b/valid%b required=halt0/valid0", id_halt, id_valid);
    end
    flush = 1'b0;
    tick();
    checks++;
    if (id_halt !== 1'b0 || id_instruction !== 16'h1111 || stall !== 1'b0) begin
      errors++;
      $display("FAIL after_squash got=%b/%h/%b required=0/1111/0", id_halt, id_instruction, stall);
    end
  endtask

  task automatic test_halt();
    drive(16'hF000, 16'h0060, 1'b0, 1'b0);
    tick();
    checks++;
    if (stall !== 1'b1 || id_halt !== 1'b0 || id_instruction !== 16'hF000) begin
      errors++;
      $display("FAIL halt_in_slot got=stall%b/halt%b/%h required=stall1/halt0/f000",
               stall, id_halt, id_instruction);
    end
    tick();
    checks++;
    if (id_halt !== 1'b1) begin
      errors++;
      $display("FAIL halt_set got=%b required=1", id_halt);
    end
    for (int i = 0; i < 10; i++) begin
      drive(16'($urandom), 16'($urandom), 1'(i % 2), 1'($urandom_range(0, 1)));
      tick();
      checks++;
      if ({id_instruction, id_PC, id_valid, id_halt, stall} !== {16'hF000, 16'h0060, 1'b1, 1'b1, 1'b1}) begin
        errors++;
        $display("FAIL halt_frozen[%0d] got=%h/%h/%b/%b/%b required=f000/0060/1/1/1",
                 i, id_instruction, id_PC, id_valid, id_halt, stall);
      end
    end
    drive(16'h0000, 16'h0000, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({id_instruction, id_PC, id_PC_plus_two, id_valid, id_halt, stall} !==
        {BUBBLE, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL async_reset_halt got=%h/%h/%h/%b/%b/%b required=%h/0000/0000/0/0/0",
               id_instruction, id_PC, id_PC_plus_two, id_valid, id_halt, stall, BUBBLE);
    end
    rst_n = 1'b1;
    drive(16'h6789, 16'h0070, 1'b0, 1'b0);
    tick();
    checks++;
    if ({id_instruction, id_PC, id_PC_plus_two, id_valid, id_halt} !==
        {16'h6789, 16'h0070, 16'h0072, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL load_after_reset got=%h/%h/%h/%b/%b required=6789/0070/0072/1/0",
               id_instruction, id_PC, id_PC_plus_two, id_valid, id_halt);
    end
  endtask

  task automatic test_random();
    int halted_cycles = 0;
    for (int i = 0; i < 400; i++) begin
      logic [15:0] ins;
      ins = 16'($urandom);
      if (ins[15:12] == 4'hF && $urandom_range(0, 5) != 0) ins[15:12] = 4'h2;
      drive(ins, 16'($urandom), $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0);
      idex_mem_read = 1'($urandom_range(0, 1));
      idex_rd = ($urandom_range(0, 1) == 1) ? m_instr[7:4] : 4'($urandom);
      if (m_halt) halted_cycles++;
      if (halted_cycles > 4 || $urandom_range(0, 60) == 0) begin
        #2 rst_n = 1'b0;
        model_reset();
        halted_cycles = 0;
      end
      #1;
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL random[%0d] got=%h required=%h", i, dut_vec(), exp_vec());
      end
      rst_n = 1'b1;
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_hazard();
    test_flush_priority();
    test_halt_flush();
    test_halt();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
